// File: rtl/trashbin_bus_pkg.sv
// Shared types and helpers for the TrashbinCore memory-bus fabric.
package trashbin_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } busState_t;

  // Read-error pattern; supports data buses up to 64 bits wide.
  localparam logic [63:0] BUS_ERR_DATA = '1;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  function automatic int idxWidth(input int numSlaves);
    return (clog2(numSlaves) < 1) ? 1 : clog2(numSlaves);
  endfunction

endpackage

// File: rtl/trashbin_bus_decoder.sv
// Combinational region decoder: upper master address bits to slave index plus miss flag.
module trashbin_bus_decoder
  import trashbin_bus_pkg::*;
#(
  parameter int NUM_SLAVES   = 4,
  parameter int ADDR_W       = 32,
  parameter int SLAVE_ADDR_W = 14,
  localparam int IDX_W       = idxWidth(NUM_SLAVES),
  localparam int REGION_W    = ADDR_W - SLAVE_ADDR_W
) (
  input  logic [REGION_W-1:0] regionBits,
  output logic [IDX_W-1:0]    slaveIdx,
  output logic                miss
);

  localparam logic [IDX_W:0] IDX_LIMIT = (IDX_W + 1)'(NUM_SLAVES);

  logic upperSet;
  logic idxOutOfRange;

  assign slaveIdx      = regionBits[IDX_W-1:0];
  assign idxOutOfRange = ({1'b0, slaveIdx} >= IDX_LIMIT);

  if (REGION_W > IDX_W) begin : gUpper
    assign upperSet = |regionBits[REGION_W-1:IDX_W];
  end else begin : gNoUpper
    assign upperSet = 1'b0;
  end

  assign miss = idxOutOfRange | upperSet;

endmodule

// File: rtl/trashbin_bus_fabric.sv
// Single-master bus fabric: decode, one-hot slave strobes, variable latency, registered response.
// Optional access timeout enabled by defining BUS_TIMEOUT_EN.
module trashbin_bus_fabric
  import trashbin_bus_pkg::*;
#(
  parameter int NUM_SLAVES     = 4,
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 32,
  parameter int SLAVE_ADDR_W   = 14,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                         CoreClock,
  input  logic                         ResetN,
  input  logic [ADDR_W-1:0]            AddressBus,
  input  logic [DATA_W-1:0]            DataWriteBus,
  input  logic                         WriteAssert,
  input  logic                         ReadAssert,
  output logic [DATA_W-1:0]            DataReadBus,
  output logic                         ReadOK,
  output logic                         WriteOK,
  output logic                         BusError,
  output logic [SLAVE_ADDR_W-1:0]      SlaveAddress,
  output logic [DATA_W-1:0]            SlaveWriteData,
  output logic [NUM_SLAVES-1:0]        SlaveWrite,
  output logic [NUM_SLAVES-1:0]        SlaveRead,
  input  logic [NUM_SLAVES*DATA_W-1:0] SlaveReadData,
  input  logic [NUM_SLAVES-1:0]        SlaveReady
);

  localparam int IDX_W = idxWidth(NUM_SLAVES);

  busState_t state, stateNext;

  logic [IDX_W-1:0]      decIdx;
  logic                  decMiss;
  logic [NUM_SLAVES-1:0] decOneHot;
  logic                  request;

  logic [IDX_W-1:0]      idx_p0;
  logic                  miss_p0;
  logic                  isWrite_p0;

  logic                  selReady;
  logic [DATA_W-1:0]     selData;
  logic                  timedOut;
  logic                  accessDone;
  logic                  accessErr;

  trashbin_bus_decoder #(
    .NUM_SLAVES  (NUM_SLAVES),
    .ADDR_W      (ADDR_W),
    .SLAVE_ADDR_W(SLAVE_ADDR_W)
  ) uDecoder (
    .regionBits(AddressBus[ADDR_W-1:SLAVE_ADDR_W]),
    .slaveIdx  (decIdx),
    .miss      (decMiss)
  );

  assign request   = WriteAssert | ReadAssert;
  assign decOneHot = NUM_SLAVES'(1) << decIdx;
  assign selReady  = SlaveReady[idx_p0];
  assign selData   = SlaveReadData[int'(idx_p0) * DATA_W +: DATA_W];

`ifdef BUS_TIMEOUT_EN
  localparam int TO_BITS = clog2(TIMEOUT_CYCLES + 1);
  localparam int TO_W    = (TO_BITS < 8) ? 8 : ((TO_BITS > 16) ? 16 : TO_BITS);

  logic [TO_W-1:0] toCount;

  // Counts ACCESS cycles; restarts from zero on every entry into ACCESS.
  always_ff @(posedge CoreClock or negedge ResetN) begin
    if (!ResetN) begin
      toCount <= '0;
    end else if (state != ACCESS) begin
      toCount <= '0;
    end else begin
      toCount <= toCount + 1'b1;
    end
  end

  assign timedOut = (state == ACCESS) && (toCount == TO_W'(TIMEOUT_CYCLES - 1));
`else
  localparam int unusedTimeoutCycles = TIMEOUT_CYCLES;
  assign timedOut = 1'b0;
`endif

  // A miss spends one silent ACCESS cycle so error and hit responses share the same latency.
  assign accessDone = miss_p0 | selReady | timedOut;
  assign accessErr  = miss_p0 | (timedOut & ~selReady);

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (request) stateNext = ACCESS;
      ACCESS:  if (accessDone) stateNext = RESP;
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge CoreClock or negedge ResetN) begin
    if (!ResetN) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Request latch (p0) and registered response outputs.
  always_ff @(posedge CoreClock or negedge ResetN) begin
    if (!ResetN) begin
      idx_p0         <= '0;
      miss_p0        <= 1'b0;
      isWrite_p0     <= 1'b0;
      SlaveAddress   <= '0;
      SlaveWriteData <= '0;
      SlaveWrite     <= '0;
      SlaveRead      <= '0;
      ReadOK         <= 1'b0;
      WriteOK        <= 1'b0;
      BusError       <= 1'b0;
      DataReadBus    <= '0;
    end else begin
      SlaveWrite <= '0;
      SlaveRead  <= '0;
      ReadOK     <= 1'b0;
      WriteOK    <= 1'b0;
      BusError   <= 1'b0;
      case (state)
        IDLE: begin
          if (request) begin
            idx_p0         <= decIdx;
            miss_p0        <= decMiss;
            isWrite_p0     <= WriteAssert;
            SlaveAddress   <= AddressBus[SLAVE_ADDR_W-1:0];
            SlaveWriteData <= DataWriteBus;
            if (!decMiss) begin
              if (WriteAssert) SlaveWrite <= decOneHot;
              else             SlaveRead  <= decOneHot;
            end
          end
        end
        ACCESS: begin
          if (accessDone) begin
            WriteOK  <= isWrite_p0;
            ReadOK   <= ~isWrite_p0;
            BusError <= accessErr;
            if (!isWrite_p0) begin
              DataReadBus <= accessErr ? BUS_ERR_DATA[DATA_W-1:0] : selData;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
